// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared core definitions for the instruction-fetch slice: architectural word
// width, instruction size in bytes, default reset PC and the {pc, instr} entry
// that is buffered between fetch and decode.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int CORE_XLEN   = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [CORE_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits so any address becomes a word address.
    function automatic logic [CORE_XLEN-1:0] word_align(input logic [CORE_XLEN-1:0] addr);
        return {addr[CORE_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch unit's external buses: the instruction-memory address /
// data pair, the decode-side valid/ready handshake with {pc, instr}, and the
// redirect request from execute.
//   master : the fetch unit (drives address and decode outputs)
//   slave  : the environment (memory, decode, execute)
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic [DATA_WIDTH-1:0] imem_instr_i;
    logic                  instr_valid_o;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  instr_ready_i;
    logic                  redirect_valid_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;

    modport master (
        output imem_addr_o,
        input  imem_instr_i,
        output instr_valid_o,
        output instr_o,
        output pc_o,
        input  instr_ready_i,
        input  redirect_valid_i,
        input  redirect_pc_i
    );

    modport slave (
        input  imem_addr_o,
        output imem_instr_i,
        input  instr_valid_o,
        input  instr_o,
        input  pc_o,
        output instr_ready_i,
        output redirect_valid_i,
        output redirect_pc_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO of fetch_entry_t with a flush that takes priority over
// push/pop. The head entry is read combinationally from storage.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : drop all entries and reset pointers
//   push/pop   : enqueue wr_entry / dequeue head (caller guarantees legality)
//   wr_entry   : entry written at the tail on push
//   head       : entry at the read pointer
//   count      : number of valid entries
//   full       : count == DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointer, count and storage update; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wr_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch initiator. Owns the fetch PC, presents it to a
// combinational instruction memory, and pushes the {pc, instr} pair into a
// small FIFO toward decode. A redirect from execute flushes the FIFO and
// restarts fetch at the (word-aligned) target.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (imem address/data, decode valid/ready with
//          pc/instr, redirect request)
// The memory address is the PC register itself, so neither ready nor redirect
// has a combinational path to it.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] fetch_pc_r;
    logic                  valid_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  full_s;
    logic [CNT_W-1:0]      count_s;
    fetch_entry_t          wr_entry_s;
    fetch_entry_t          head_s;

    assign valid_s = (count_s != CNT_W'(1'b0));
    assign pop_s   = valid_s & bus.instr_ready_i;
    // A pop frees a slot in the same cycle, so a full FIFO can still stream.
    assign push_s  = ~bus.redirect_valid_i & (~full_s | pop_s);

    assign wr_entry_s.pc    = fetch_pc_r;
    assign wr_entry_s.instr = bus.imem_instr_i;

    // Fetch PC: redirect target has priority, otherwise advance on each push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= word_align(RESET_PC);
        end else if (bus.redirect_valid_i) begin
            fetch_pc_r <= word_align(bus.redirect_pc_i);
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + DATA_WIDTH'(INSTR_BYTES);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.redirect_valid_i),
        .push     (push_s),
        .pop      (pop_s),
        .wr_entry (wr_entry_s),
        .head     (head_s),
        .count    (count_s),
        .full     (full_s)
    );

    assign bus.imem_addr_o   = fetch_pc_r;
    assign bus.instr_valid_o = valid_s;

    // Head presentation: stale storage is masked to zero while the FIFO is empty.
    always_comb begin
        bus.instr_o = '0;
        bus.pc_o    = '0;
        if (valid_s) begin
            bus.instr_o = head_s.instr;
            bus.pc_o    = head_s.pc;
        end else begin
            bus.instr_o = '0;
            bus.pc_o    = '0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Memory word at byte address a is
// 32'h0010_0093 + (a >> 2). A second instance with RESET_PC = 32'hFFFF_FFF8
// covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [31:0] BASE = 32'h0010_0093;

    fetch_unit_if #(.DATA_WIDTH(32)) bus ();
    fetch_unit_if #(.DATA_WIDTH(32)) bus_w ();

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (2)
    ) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    assign bus.imem_instr_i   = BASE + (bus.imem_addr_o >> 2);
    assign bus_w.imem_instr_i = BASE + (bus_w.imem_addr_o >> 2);

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic rdy);
        rst                  = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = 32'h0;
        bus.instr_ready_i    = rdy;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid_o); end
        n_cmp++; if (bus.instr_o !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=0", bus.instr_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", bus.pc_o); end
        n_cmp++; if (bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr_o); end
        n_cmp++; if (bus_w.imem_addr_o !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL reset_addr_w got=%h exp=fffffff8", bus_w.imem_addr_o); end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        apply_reset(1'b1);
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_c0_valid got=%b exp=0", bus.instr_valid_o); end
        for (int k = 0; k < 3; k++) begin
            step();
            epc = 32'(k) * 32'd4;
            n_cmp++; if (bus.instr_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.instr_valid_o); end
            n_cmp++; if (bus.pc_o !== epc) begin n_err++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.pc_o, epc); end
            n_cmp++; if (bus.instr_o !== BASE + 32'(k)) begin n_err++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus.instr_o, BASE + 32'(k)); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] epc [3];
        logic [31:0] ein [3];
        epc[0] = 32'hFFFF_FFF8; ein[0] = 32'h4010_0091;
        epc[1] = 32'hFFFF_FFFC; ein[1] = 32'h4010_0092;
        epc[2] = 32'h0000_0000; ein[2] = 32'h0010_0093;
        apply_reset(1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (bus_w.pc_o !== epc[k]) begin n_err++; $display("FAIL wrap_pc k=%0d got=%h exp=%h", k, bus_w.pc_o, epc[k]); end
            n_cmp++; if (bus_w.instr_o !== ein[k]) begin n_err++; $display("FAIL wrap_instr k=%0d got=%h exp=%h", k, bus_w.instr_o, ein[k]); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        step();
        n_cmp++; if (bus.imem_addr_o !== 32'h4) begin n_err++; $display("FAIL bp_addr1 got=%h exp=4", bus.imem_addr_o); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bus.imem_addr_o !== 32'h8) begin n_err++; $display("FAIL bp_addr_hold got=%h exp=8", bus.imem_addr_o); end
        n_cmp++; if (dut.u_fifo.count !== 2'd2) begin n_err++; $display("FAIL bp_count got=%0d exp=2", dut.u_fifo.count); end
        n_cmp++; if (bus.instr_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%b exp=1", bus.instr_valid_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL bp_head_pc got=%h exp=0", bus.pc_o); end
        n_cmp++; if (bus.instr_o !== BASE) begin n_err++; $display("FAIL bp_head_instr got=%h exp=%h", bus.instr_o, BASE); end
        bus.instr_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            n_cmp++; if (bus.pc_o !== 32'(k) * 32'd4) begin n_err++; $display("FAIL bp_drain_pc k=%0d got=%h exp=%h", k, bus.pc_o, 32'(k) * 32'd4); end
            n_cmp++; if (bus.instr_o !== BASE + 32'(k)) begin n_err++; $display("FAIL bp_drain_instr k=%0d got=%h exp=%h", k, bus.instr_o, BASE + 32'(k)); end
        end
        // FIFO now full (pc 12, 16) with ready high, fetch_pc = 20.
        n_cmp++; if (dut.u_fifo.count !== 2'd2) begin n_err++; $display("FAIL bp_stream_count got=%0d exp=2", dut.u_fifo.count); end
    endtask

    task automatic test_redirect();
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h40;
        #1;
        n_cmp++; if (bus.imem_addr_o !== 32'h14) begin n_err++; $display("FAIL redir_no_comb_addr got=%h exp=14", bus.imem_addr_o); end
        step();
        bus.redirect_valid_i = 1'b0;
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_n1_valid got=%b exp=0", bus.instr_valid_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL redir_n1_pc got=%h exp=0", bus.pc_o); end
        n_cmp++; if (bus.imem_addr_o !== 32'h40) begin n_err++; $display("FAIL redir_n1_addr got=%h exp=40", bus.imem_addr_o); end
        step();
        n_cmp++; if (bus.instr_valid_o !== 1'b1) begin n_err++; $display("FAIL redir_n2_valid got=%b exp=1", bus.instr_valid_o); end
        n_cmp++; if (bus.pc_o !== 32'h40) begin n_err++; $display("FAIL redir_n2_pc got=%h exp=40", bus.pc_o); end
        n_cmp++; if (bus.instr_o !== 32'h0010_00A3) begin n_err++; $display("FAIL redir_n2_instr got=%h exp=001000a3", bus.instr_o); end
        step();
        n_cmp++; if (bus.pc_o !== 32'h44) begin n_err++; $display("FAIL redir_n3_pc got=%h exp=44", bus.pc_o); end
    endtask

    task automatic test_misaligned();
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h43;
        step();
        bus.redirect_valid_i = 1'b0;
        n_cmp++; if (bus.imem_addr_o !== 32'h40) begin n_err++; $display("FAIL misalign_addr got=%h exp=40", bus.imem_addr_o); end
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL misalign_valid got=%b exp=0", bus.instr_valid_o); end
        step();
        n_cmp++; if (bus.pc_o !== 32'h40) begin n_err++; $display("FAIL misalign_pc got=%h exp=40", bus.pc_o); end
    endtask

    task automatic test_async_reset();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b exp=0", bus.instr_valid_o); end
        n_cmp++; if (bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL arst_addr got=%h exp=0", bus.imem_addr_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL arst_pc got=%h exp=0", bus.pc_o); end
        n_cmp++; if (bus_w.imem_addr_o !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL arst_addr_w got=%h exp=fffffff8", bus_w.imem_addr_o); end
        #2;
        rst = 1'b0;
        step();
        n_cmp++; if (bus.instr_valid_o !== 1'b1) begin n_err++; $display("FAIL arst_resume_valid got=%b exp=1", bus.instr_valid_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL arst_resume_pc got=%h exp=0", bus.pc_o); end
        n_cmp++; if (bus.instr_o !== BASE) begin n_err++; $display("FAIL arst_resume_instr got=%h exp=%h", bus.instr_o, BASE); end
        step();
        n_cmp++; if (bus.pc_o !== 32'h4) begin n_err++; $display("FAIL arst_resume_pc2 got=%h exp=4", bus.pc_o); end
    endtask

    initial begin
        bus.instr_ready_i      = 1'b0;
        bus.redirect_valid_i   = 1'b0;
        bus.redirect_pc_i      = 32'h0;
        bus_w.instr_ready_i    = 1'b1;
        bus_w.redirect_valid_i = 1'b0;
        bus_w.redirect_pc_i    = 32'h0;
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
